// File: rtl/accum_window_reporter_if.sv
// Report bus from accum_window_reporter to its consumer.
// Master drives rpt_valid and the rpt_* fields; slave drives rpt_ready.
// rpt_range exists only when REPORT_RANGE_EN is defined.
interface accum_window_reporter_if;
    logic        rpt_valid;
    logic        rpt_ready;
    logic [31:0] rpt_sum;
    logic [15:0] rpt_mean;
    logic [15:0] rpt_min;
    logic [15:0] rpt_max;
    logic [15:0] rpt_index;
    logic [1:0]  rpt_status;
`ifdef REPORT_RANGE_EN
    logic [16:0] rpt_range;
`endif

    modport master (
`ifdef REPORT_RANGE_EN
        output rpt_range,
`endif
        output rpt_valid,
        output rpt_sum,
        output rpt_mean,
        output rpt_min,
        output rpt_max,
        output rpt_index,
        output rpt_status,
        input  rpt_ready
    );

    modport slave (
`ifdef REPORT_RANGE_EN
        input  rpt_range,
`endif
        input  rpt_valid,
        input  rpt_sum,
        input  rpt_mean,
        input  rpt_min,
        input  rpt_max,
        input  rpt_index,
        input  rpt_status,
        output rpt_ready
    );
endinterface

// File: rtl/accum_window_reporter.sv
// Windowed report generator behind the signed running accumulator.
// Inputs: clk, reset (async, active-high), acc, cycle_count, min_val,
// max_val, overflow_flag, underflow_flag. Outputs: rpt (report bus,
// master modport), drop_count, halted. Optional macro REPORT_RANGE_EN
// adds rpt_range = max_val - min_val at window close.
module accum_window_reporter #(
    parameter int LOG2_WIN = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [31:0]             acc,
    input  logic [31:0]             cycle_count,
    input  logic [15:0]             min_val,
    input  logic [15:0]             max_val,
    input  logic                    overflow_flag,
    input  logic                    underflow_flag,
    accum_window_reporter_if.master rpt,
    output logic [7:0]              drop_count,
    output logic                    halted
);
    typedef enum logic [1:0] {
        COLLECT,
        HALT_PEND,
        HALTED
    } state_e;

    typedef struct packed {
        logic [31:0] sum;
        logic [15:0] lo;
        logic [15:0] hi;
        logic [15:0] idx;
        logic [1:0]  status;
`ifdef REPORT_RANGE_EN
        logic [16:0] spread;
`endif
    } report_t;

    state_e      state_q, state_d;
    logic [31:0] base_q, base_d;
    logic [31:0] prev_count_q, prev_count_d;
    logic [15:0] win_idx_q, win_idx_d;
    logic [7:0]  drop_q, drop_d;
    logic        halted_q, halted_d;
    logic        valid_q, valid_d;
    // final report already sits in the output register
    logic        fin_held_q, fin_held_d;
    report_t     out_q, out_d;
    // final report waiting for the output register to free up
    report_t     stg_q, stg_d;

    report_t     cand;
    logic        flag;
    logic        boundary;
    logic        can_load;
    logic        accept;
    logic signed [31:0] sum_s;

    always_comb begin
        cand        = '0;
        cand.sum    = acc - base_q;
        cand.lo     = min_val;
        cand.hi     = max_val;
        cand.idx    = win_idx_q;
        cand.status = {underflow_flag, overflow_flag};
`ifdef REPORT_RANGE_EN
        // max < min means no samples yet
        if ($signed(max_val) < $signed(min_val)) begin
            cand.spread = '0;
        end else begin
            cand.spread = {max_val[15], max_val}
                        - {min_val[15], min_val};
        end
`endif
    end

    assign flag     = overflow_flag | underflow_flag;
    assign boundary = (cycle_count != prev_count_q)
                   && (cycle_count[LOG2_WIN-1:0] == '0);
    assign accept   = valid_q & rpt.rpt_ready;
    assign can_load = ~valid_q | rpt.rpt_ready;

    always_comb begin
        state_d      = state_q;
        base_d       = base_q;
        prev_count_d = cycle_count;
        win_idx_d    = win_idx_q;
        drop_d       = drop_q;
        halted_d     = halted_q;
        valid_d      = valid_q & ~accept;
        fin_held_d   = fin_held_q;
        out_d        = out_q;
        stg_d        = stg_q;
        unique case (state_q)
            COLLECT: begin
                if (flag) begin
                    // saturation beats a coincident window close
                    state_d = HALT_PEND;
                    if (can_load) begin
                        out_d      = cand;
                        valid_d    = 1'b1;
                        fin_held_d = 1'b1;
                    end else begin
                        stg_d = cand;
                    end
                end else if (boundary) begin
                    base_d    = acc;
                    win_idx_d = win_idx_q + 16'd1;
                    if (can_load) begin
                        out_d   = cand;
                        valid_d = 1'b1;
                    end else if (drop_q != 8'hFF) begin
                        drop_d = drop_q + 8'd1;
                    end
                end
            end
            HALT_PEND: begin
                if (fin_held_q) begin
                    if (accept) begin
                        state_d  = HALTED;
                        halted_d = 1'b1;
                    end
                end else if (can_load) begin
                    out_d      = stg_q;
                    valid_d    = 1'b1;
                    fin_held_d = 1'b1;
                end
            end
            HALTED: begin
                halted_d = 1'b1;
            end
            default: begin
                state_d = COLLECT;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= COLLECT;
            base_q       <= '0;
            prev_count_q <= '0;
            win_idx_q    <= '0;
            drop_q       <= '0;
            halted_q     <= 1'b0;
            valid_q      <= 1'b0;
            fin_held_q   <= 1'b0;
            out_q        <= '0;
            stg_q        <= '0;
        end else begin
            state_q      <= state_d;
            base_q       <= base_d;
            prev_count_q <= prev_count_d;
            win_idx_q    <= win_idx_d;
            drop_q       <= drop_d;
            halted_q     <= halted_d;
            valid_q      <= valid_d;
            fin_held_q   <= fin_held_d;
            out_q        <= out_d;
            stg_q        <= stg_d;
        end
    end

    assign sum_s          = $signed(out_q.sum);
    assign rpt.rpt_valid  = valid_q;
    assign rpt.rpt_sum    = out_q.sum;
    assign rpt.rpt_mean   = 16'(sum_s >>> LOG2_WIN);
    assign rpt.rpt_min    = out_q.lo;
    assign rpt.rpt_max    = out_q.hi;
    assign rpt.rpt_index  = out_q.idx;
    assign rpt.rpt_status = out_q.status;
`ifdef REPORT_RANGE_EN
    assign rpt.rpt_range  = out_q.spread;
`endif
    assign drop_count     = drop_q;
    assign halted         = halted_q;
endmodule

// File: doc/accum_window_reporter.md
# accum_window_reporter

Downstream consumer of the signed running accumulator stage. Monitors the accumulator's `acc`, `cycle_count`, `min_val`, `max_val` and overflow/underflow flags, and closes a report every 2^LOG2_WIN accepted samples. Each report holds the window sum, the window mean, a snapshot of min/max, the window index and status. Reports leave over a valid/ready interface. On accumulator saturation the block issues one guaranteed final report and then halts.

## Interface
- `LOG2_WIN`, 2: window length is 2^LOG2_WIN samples; legal range 1..15.
- `clk`  in  1  rising-edge clock, shared with the accumulator.
- `reset`  in  1  asynchronous, active-high reset.
- `acc`  in  32  signed running sum from the accumulator (registered).
- `cycle_count`  in  32  the accumulator's sample counter (registered).
- `min_val`, `max_val`  in  16 each  signed cumulative extremes.
- `overflow_flag`, `underflow_flag`  in  1 each  sticky saturation flags.
- `rpt_ready`  in  1  the consumer accepts a report.
- `rpt_valid`  out  1  a report is held on the `rpt_*` outputs.
- `rpt_sum`  out  32  signed: `acc` at close minus `acc` at window start.
- `rpt_mean`  out  16  signed: low 16 bits of (`rpt_sum` >>> LOG2_WIN).
- `rpt_min`, `rpt_max`  out  16 each  snapshot of `min_val`/`max_val` at close.
- `rpt_index`  out  16  window number; the first window is 0; wraps at 0xFFFF.
- `rpt_status`  out  2  {underflow, overflow}; non-zero only on the final report.
- `drop_count`  out  8  saturating count of discarded window reports.
- `halted`  out  1  the final report has been accepted.

## Operation
- **State register:** COLLECT, HALT_PEND, HALTED. A separate output holding register carries the report fields.
- **Internal registers:** `base` (32, `acc` at window start), `prev_count` (32), `win_idx` (16).
- **Window close:** occurs in COLLECT when `cycle_count != prev_count`, `cycle_count[LOG2_WIN-1:0] == 0`, and both flags are 0.
  - Report is formed: sum = `acc - base` (32-bit two's complement), mean = arithmetic shift (floor toward −inf).
  - `base <= acc`; `win_idx` increments.
- **Load rule:** the report loads if the holding register is empty (`!rpt_valid`) or is being accepted that cycle (`rpt_valid & rpt_ready`). Otherwise the new report is discarded and `drop_count` increments, saturating at 255.
- **Saturation:** in COLLECT, if either flag is 1, form the final report.
  - Fields: sum = `acc - base` (partial window), status = {`underflow_flag`, `overflow_flag`}, index = current `win_idx`.
  - If it loads, go to HALTED once it is accepted; otherwise go to HALT_PEND.
  - The final report is never dropped.
- **Simultaneous close and flag:** the flag wins. Exactly one report, the final one, is issued. No drop is counted.
- **HALT_PEND:** keeps the final report staged and loads it on the first cycle the load rule permits.
- **HALTED:** `halted=1`. All inputs are ignored; only `reset` exits this state.
- **`prev_count`** updates to `cycle_count` every cycle.
- **Reset values:** every output is 0; state is COLLECT; `base`, `prev_count` and `win_idx` are 0.

## Timing
- A report is visible on the outputs one edge after the cycle in which the close condition is true on the inputs.
- **Transfer:** happens on the edge where `rpt_valid & rpt_ready`.
  - `rpt_valid` falls on that edge unless a new report loads on the same edge, in which case it stays 1.
- **Hold while stalled:** while `rpt_valid & !rpt_ready`, all `rpt_*` outputs stay stable.
- **`rpt_valid`** is independent of `rpt_ready`; there is no combinational path from `rpt_ready` to `rpt_valid`.
- **`halted`** rises on the edge that accepts the final report.
- **Reset mid-window or mid-stall:** asynchronous. The pending report is lost, and `rpt_valid` and `halted` clear immediately.
- **Throughput:** one report per window, provided `rpt_ready` is high within 2^LOG2_WIN cycles of each report.

## Configuration
- `REPORT_RANGE_EN` defined:
  - Adds output `rpt_range` (17, unsigned) = `max_val - min_val` at close, computed sign-extended to 17 bits and registered with the other report fields.
  - Reads as 0 when `max_val < min_val` (no samples seen yet).
  - Reset value is 0.
- `REPORT_RANGE_EN` undefined: the port and its logic are absent. All other behaviour is identical.

## Test plan
All scenarios use LOG2_WIN=2 (window of 4) and a bench model of the accumulator.
- **Constant positive input:** constant +3 with `rpt_ready=1` -> reports index 0,1,2 each with sum 12, mean 3, status 0, `drop_count` 0.
- **Rounding toward −inf:** window 1,1,1,2 -> sum 5, mean 1. Window −1,−1,−1,−2 -> sum −5, mean −2.
- **Backpressure:**
  - Hold `rpt_ready=0` for 10 windows -> index 0 held stable and `drop_count=10`.
  - Release -> the next report is index 11 with a correct sum.
  - 300 stalled windows -> `drop_count` saturates at 255.
- **Overflow, mid-window:** start at `acc` near 0x7FFFFFF0, then drive +0x7FFF -> one final report with status 01 and the partial-window sum, then `halted=1`. No further reports follow despite input activity.
- **Overflow at a window boundary while stalled:** overflow lands on a boundary cycle with `rpt_ready=0` and a report already held -> state is HALT_PEND and no drop is counted. Raising `rpt_ready` delivers the held report, then the final report, then `halted=1`.
- **Reset mid-stall:** assert `reset` while `rpt_valid=1` and stalled -> all outputs are 0 immediately. After release, the first report is index 0 with the correct sum.
